// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control FSM: state register, retire counter and
// combinational datapath control decoded from state plus IR fields.
module multicycle_ctrl_fsm #(
  parameter bit MEM_WAIT     = 1'b1,
  parameter bit TRAP_ILLEGAL = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic             mem_ready,
  output logic [3:0]       state,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_control,
  output logic [2:0]       imm_src,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EX_R   = 4'd2,
    S_EX_I   = 4'd3,
    S_EX_S   = 4'd4,
    S_EX_J   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,
    S_WB_MEM = 4'd9,
    S_HALT   = 4'd10,
    S_EX_B   = 4'd11,
    S_EX_JR  = 4'd12,
    S_EX_U   = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] A_AND  = 4'b0000;
  localparam logic [3:0] A_OR   = 4'b0001;
  localparam logic [3:0] A_ADD  = 4'b0010;
  localparam logic [3:0] A_XOR  = 4'b0011;
  localparam logic [3:0] A_SLL  = 4'b0100;
  localparam logic [3:0] A_SRL  = 4'b0101;
  localparam logic [3:0] A_SUB  = 4'b0110;
  localparam logic [3:0] A_SLT  = 4'b0111;
  localparam logic [3:0] A_SRA  = 4'b1000;
  localparam logic [3:0] A_SLTU = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // Illegal encodings either trap for good or fall back to fetch
  localparam state_t S_BAD = TRAP_ILLEGAL ? S_TRAP : S_IF;

  state_t     st, nxt;
  logic       rdy, retire;
  logic       mr, mw, irw, pcw, rw;
  logic       r_ok, br_ok, taken;
  logic [3:0] r_alu, i_alu;

  assign rdy = mem_ready | ~MEM_WAIT;

  always_comb begin
    r_ok  = 1'b1;
    r_alu = A_ADD;
    case ({funct7, funct3})
      10'b0000000_000: r_alu = A_ADD;
      10'b0000000_001: r_alu = A_SLL;
      10'b0000000_010: r_alu = A_SLT;
      10'b0000000_011: r_alu = A_SLTU;
      10'b0000000_100: r_alu = A_XOR;
      10'b0000000_101: r_alu = A_SRL;
      10'b0000000_110: r_alu = A_OR;
      10'b0000000_111: r_alu = A_AND;
      10'b0100000_000: r_alu = A_SUB;
      10'b0100000_101: r_alu = A_SRA;
      default:         r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    i_alu = A_ADD;
    case (funct3)
      3'b000: i_alu = A_ADD;
      3'b001: i_alu = A_SLL;
      3'b010: i_alu = A_SLT;
      3'b011: i_alu = A_SLTU;
      3'b100: i_alu = A_XOR;
      3'b101: i_alu = (funct7 == 7'b0100000) ? A_SRA : A_SRL;
      3'b110: i_alu = A_OR;
      default: i_alu = A_AND;
    endcase
  end

  always_comb begin
    br_ok = 1'b1;
    taken = 1'b0;
    case (funct3)
      3'b000: taken = zero;
      3'b001: taken = ~zero;
      3'b100: taken = lt;
      3'b101: taken = ~lt;
      3'b110: taken = ltu;
      3'b111: taken = ~ltu;
      default: br_ok = 1'b0;
    endcase
  end

  always_comb begin
    nxt         = st;
    retire      = 1'b0;
    mr          = 1'b0;
    mw          = 1'b0;
    irw         = 1'b0;
    pcw         = 1'b0;
    rw          = 1'b0;
    pc_src      = 1'b0;
    mem_to_reg  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = A_ADD;
    imm_src     = IMM_I;
    unique case (st)
      S_IF: begin
        mr        = 1'b1;
        alu_src_b = 2'b10;
        if (rdy) begin
          irw = 1'b1;
          pcw = 1'b1;
          nxt = S_ID;
        end
      end
      S_ID: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_IMM:  nxt = S_EX_I;
          OP_STORE:         nxt = S_EX_S;
          OP_OP:            nxt = S_EX_R;
          OP_BRANCH:        nxt = S_EX_B;
          OP_JAL:           nxt = S_EX_J;
          OP_JALR:          nxt = S_EX_JR;
          OP_LUI, OP_AUIPC: nxt = S_EX_U;
          OP_SYSTEM:
            nxt = (funct3 == 3'b000) ? S_HALT : S_BAD;
          default:          nxt = S_BAD;
        endcase
      end
      S_EX_R: begin
        alu_src_a   = 2'b10;
        alu_control = r_alu;
        nxt         = r_ok ? S_WB_ALU : S_BAD;
      end
      S_EX_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (opcode == OP_LOAD) begin
          nxt = S_MEM_RD;
        end else begin
          alu_control = i_alu;
          nxt         = S_WB_ALU;
        end
      end
      S_EX_S: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = IMM_S;
        nxt       = S_MEM_WR;
      end
      S_MEM_RD: begin
        mr = 1'b1;
        if (rdy) nxt = S_WB_MEM;
      end
      S_MEM_WR: begin
        mw = 1'b1;
        if (rdy) begin
          nxt    = S_IF;
          retire = 1'b1;
        end
      end
      S_WB_ALU: begin
        rw = 1'b1;
        if (opcode == OP_JAL || opcode == OP_JALR)
          mem_to_reg = 2'b10;
        nxt    = S_IF;
        retire = 1'b1;
      end
      S_WB_MEM: begin
        rw         = 1'b1;
        mem_to_reg = 2'b01;
        nxt        = S_IF;
        retire     = 1'b1;
      end
      S_EX_B: begin
        alu_src_a   = 2'b10;
        alu_control = A_SUB;
        imm_src     = IMM_B;
        pc_src      = 1'b1;
        pcw         = br_ok & taken;
        nxt         = br_ok ? S_IF : S_BAD;
        retire      = br_ok;
      end
      S_EX_J: begin
        imm_src = IMM_J;
        pc_src  = 1'b1;
        pcw     = 1'b1;
        nxt     = S_WB_ALU;
      end
      S_EX_JR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        pcw       = 1'b1;
        nxt       = S_WB_ALU;
      end
      S_EX_U: begin
        imm_src   = IMM_U;
        alu_src_b = 2'b01;
        alu_src_a = (opcode == OP_LUI) ? 2'b11 : 2'b01;
        nxt       = S_WB_ALU;
      end
      S_HALT, S_TRAP: nxt = st;
      default: nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st      <= S_IF;
      instret <= '0;
    end else begin
      st <= nxt;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  // Strobes drop combinationally with reset, even mid-access
  assign mem_read  = resetn & mr;
  assign mem_write = resetn & mw;
  assign ir_write  = resetn & irw;
  assign pc_write  = resetn & pcw;
  assign reg_write = resetn & rw;

  assign state   = st;
  assign halted  = (st == S_HALT);
  assign illegal = (st == S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench: default config, CNT_W=4 and TRAP_ILLEGAL=0
// instances driven by shared stimulus.
module tb_multicycle_ctrl_fsm;

  logic clk = 1'b0;
  logic resetn;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic zero, lt, ltu, mem_ready;

  logic [3:0] state, alu_control;
  logic mem_read, mem_write, ir_write, pc_write;
  logic pc_src, reg_write, halted, illegal;
  logic [1:0] mem_to_reg, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [31:0] instret;

  logic [3:0] st4, alu4;
  logic mr4, mw4, irw4, pcw4, pcs4, rw4, h4, il4;
  logic [1:0] m2r4, sa4, sb4;
  logic [2:0] imm4;
  logic [3:0] ret4;

  logic [3:0] st2, alu2;
  logic mr2, mw2, irw2, pcw2, pcs2, rw2, h2, il2;
  logic [1:0] m2r2, sa2, sb2;
  logic [2:0] imm2;
  logic [31:0] ret2;

  int n_chk = 0;
  int n_fail = 0;
  int irw_cnt;
  logic [4:0] acc;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm u0 (
    .clk(clk), .resetn(resetn), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .zero(zero),
    .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .state(state), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src),
    .halted(halted), .illegal(illegal),
    .instret(instret)
  );

  multicycle_ctrl_fsm #(.CNT_W(4)) u4 (
    .clk(clk), .resetn(resetn), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .zero(zero),
    .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .state(st4), .mem_read(mr4), .mem_write(mw4),
    .ir_write(irw4), .pc_write(pcw4), .pc_src(pcs4),
    .reg_write(rw4), .mem_to_reg(m2r4),
    .alu_src_a(sa4), .alu_src_b(sb4),
    .alu_control(alu4), .imm_src(imm4),
    .halted(h4), .illegal(il4), .instret(ret4)
  );

  multicycle_ctrl_fsm #(.TRAP_ILLEGAL(1'b0)) u2 (
    .clk(clk), .resetn(resetn), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .zero(zero),
    .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .state(st2), .mem_read(mr2), .mem_write(mw2),
    .ir_write(irw2), .pc_write(pcw2), .pc_src(pcs2),
    .reg_write(rw2), .mem_to_reg(m2r2),
    .alu_src_a(sa2), .alu_src_b(sb2),
    .alu_control(alu2), .imm_src(imm2),
    .halted(h2), .illegal(il2), .instret(ret2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input string tag, input logic [2:0] f3,
                    input logic z, input logic l,
                    input logic lu, input logic exp);
    opcode = 7'b1100011;
    funct3 = f3;
    zero   = z;
    lt     = l;
    ltu    = lu;
    #1;
    chk({tag, "_if"}, 32'(state), 32'd0);
    tick();
    tick();
    chk({tag, "_st"}, 32'(state), 32'd11);
    chk({tag, "_pcw"}, 32'(pc_write), 32'(exp));
    chk({tag, "_pcs"}, 32'(pc_src), 32'd1);
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    opcode = 7'd0;
    funct3 = 3'd0;
    funct7 = 7'd0;
    zero = 1'b0;
    lt = 1'b0;
    ltu = 1'b0;
    mem_ready = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);

    // store, then reset while MEM_WR is stalled
    opcode = 7'b0100011;
    funct3 = 3'b010;
    mem_ready = 1'b1;
    resetn = 1'b1;
    #1;
    chk("st_if_irw", 32'(ir_write), 32'd1);
    tick();
    tick();
    chk("st_ex_s", 32'(state), 32'd4);
    mem_ready = 1'b0;
    tick();
    chk("st_memwr", 32'(state), 32'd7);
    chk("st_mw", 32'(mem_write), 32'd1);
    tick();
    chk("st_hold", 32'(state), 32'd7);
    resetn = 1'b0;
    #1;
    chk("st_rst_mw", 32'(mem_write), 32'd0);
    chk("st_rst_state", 32'(state), 32'd0);
    chk("st_rst_ret", instret, 32'd0);
    tick();
    resetn = 1'b1;
    mem_ready = 1'b1;

    // ADDI
    opcode = 7'b0010011;
    funct3 = 3'b000;
    funct7 = 7'd0;
    #1;
    chk("addi_if", 32'(state), 32'd0);
    tick();
    chk("addi_id", 32'(state), 32'd1);
    tick();
    chk("addi_ex", 32'(state), 32'd3);
    chk("addi_alu", 32'(alu_control), 32'd2);
    tick();
    chk("addi_wb", 32'(state), 32'd8);
    chk("addi_rw", 32'(reg_write), 32'd1);
    chk("addi_ret0", instret, 32'd0);
    tick();
    chk("addi_back", 32'(state), 32'd0);
    chk("addi_ret1", instret, 32'd1);

    // LW with wait states in IF and MEM_RD
    opcode = 7'b0000011;
    funct3 = 3'b010;
    irw_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      chk("lw_if_hold", 32'(state), 32'd0);
      irw_cnt += 32'(ir_write);
      tick();
    end
    chk("lw_irw_pulses", 32'(irw_cnt), 32'd1);
    chk("lw_id", 32'(state), 32'd1);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      #1;
      chk("lw_memrd", 32'(state), 32'd6);
      chk("lw_mr", 32'(mem_read), 32'd1);
      tick();
    end
    chk("lw_wbmem", 32'(state), 32'd9);
    chk("lw_m2r", 32'(mem_to_reg), 32'd1);
    tick();
    chk("lw_ret", instret, 32'd2);

    // branches
    br("beq_t",  3'b000, 1, 0, 0, 1'b1);
    br("beq_n",  3'b000, 0, 1, 1, 1'b0);
    br("bne_t",  3'b001, 0, 0, 0, 1'b1);
    br("blt_t",  3'b100, 0, 1, 0, 1'b1);
    br("blt_n",  3'b100, 0, 0, 1, 1'b0);
    br("bge_t",  3'b101, 0, 0, 1, 1'b1);
    br("bge_n",  3'b101, 0, 1, 0, 1'b0);
    br("bltu_t", 3'b110, 0, 0, 1, 1'b1);
    br("bltu_n", 3'b110, 0, 1, 0, 1'b0);
    br("bgeu_n", 3'b111, 0, 0, 1, 1'b0);
    chk("br_ret", instret, 32'd12);
    funct3 = 3'b010;
    tick();
    tick();
    chk("bill_pcw", 32'(pc_write), 32'd0);
    tick();
    chk("bill_trap", 32'(state), 32'd14);
    chk("bill_illegal", 32'(illegal), 32'd1);
    chk("bill_nop_if", 32'(st2), 32'd0);
    tick();
    tick();
    chk("bill_sticky", 32'(state), 32'd14);
    chk("bill_ret", instret, 32'd12);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;

    // JALR then EBREAK
    opcode = 7'b1100111;
    funct3 = 3'b000;
    tick();
    tick();
    chk("jalr_ex", 32'(state), 32'd12);
    chk("jalr_pcw", 32'(pc_write), 32'd1);
    chk("jalr_pcs", 32'(pc_src), 32'd0);
    tick();
    chk("jalr_m2r", 32'(mem_to_reg), 32'd2);
    tick();
    opcode = 7'b1110011;
    tick();
    tick();
    chk("halt_state", 32'(state), 32'd10);
    chk("halt_flag", 32'(halted), 32'd1);
    acc = '0;
    for (int i = 0; i < 20; i++) begin
      acc |= {mem_read, mem_write, ir_write,
              pc_write, reg_write};
      tick();
    end
    chk("halt_strobes", 32'(acc), 32'd0);
    chk("halt_hold", 32'(state), 32'd10);
    chk("halt_ret", instret, 32'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;

    // 17 ADDs: 4-bit counter wraps
    opcode = 7'b0110011;
    funct3 = 3'b000;
    funct7 = 7'd0;
    for (int i = 0; i < 17; i++) begin
      repeat (4) tick();
    end
    chk("wrap_ret4", 32'(ret4), 32'd1);
    chk("wrap_ret32", instret, 32'd17);
    funct7 = 7'b0100000;
    funct3 = 3'b101;
    tick();
    tick();
    chk("sra_st", 32'(state), 32'd2);
    chk("sra_alu", 32'(alu_control), 32'd8);
    tick();
    tick();
    funct7 = 7'b0000001;
    funct3 = 3'b000;
    repeat (3) tick();
    chk("rbad_trap", 32'(state), 32'd14);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;

    // illegal opcode as NOP
    opcode = 7'd0;
    tick();
    chk("nop_id", 32'(st2), 32'd1);
    tick();
    chk("nop_if", 32'(st2), 32'd0);
    chk("nop_ret", ret2, 32'd0);
    chk("nop_trap_inst", 32'(state), 32'd14);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
